// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encodings, S-box tables and the forward round primitives.
// Byte k of a 128-bit state sits at bits [127-8k -: 8]; column c is word c, row r is byte 4c+r.
package aes_pkg;
    localparam int RK_IDX_W = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic bit rounds_legal(input int n);
        return (n == 10) || (n == 12) || (n == 14);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (covers every MixColumns coefficient).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[8*(15-(4*c+w)) +: 8] = s[8*(15-(4*((c+w)%4)+w)) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[32*(3-c) +: 32];
            r[32*(3-c) +: 32] = {gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3,
                                 a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3,
                                 a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3),
                                 gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2)};
        end
        return r;
    endfunction
endpackage

// File: rtl/aes_inv_round_path.sv
// Combinational inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns.
// Zero latency, no flow control; last_i bypasses InvMixColumns for the final round.
module aes_inv_round_path
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[8*(15-(4*c+w)) +: 8] = s[8*(15-(4*((c-w+4)%4)+w)) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[32*(3-c) +: 32];
            r[32*(3-c) +: 32] = {
                gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
        end
        return r;
    endfunction

    logic [127:0] ark;

    assign ark     = inv_sub_bytes(inv_shift_rows(state_i)) ^ key_i;
    assign state_o = last_i ? ark : inv_mix_columns(ark);
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 encrypt/decrypt, one round per clock; out_valid NUM_ROUNDS clocks after accept.
// Result register holds while out_ready is low; in DONE, out_ready opens in_ready for a zero-bubble reload.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ROUNDS     = 10,
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode_in,
    input  logic [DATA_WIDTH-1:0] text_0_in,
    input  logic [DATA_WIDTH-1:0] text_1_in,
    input  logic [DATA_WIDTH-1:0] text_2_in,
    input  logic [DATA_WIDTH-1:0] text_3_in,
    output logic [RK_IDX_W-1:0]   rk_idx,
    input  logic [DATA_WIDTH-1:0] key_0_in,
    input  logic [DATA_WIDTH-1:0] key_1_in,
    input  logic [DATA_WIDTH-1:0] key_2_in,
    input  logic [DATA_WIDTH-1:0] key_3_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] text_0_out,
    output logic [DATA_WIDTH-1:0] text_1_out,
    output logic [DATA_WIDTH-1:0] text_2_out,
    output logic [DATA_WIDTH-1:0] text_3_out,
    output logic                  busy,
    output logic [RK_IDX_W-1:0]   round_cnt
);
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("aes_round_engine: DATA_WIDTH must be 32");
    end
    if (!rounds_legal(NUM_ROUNDS)) begin : g_bad_rounds
        $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
    end

    localparam logic [RK_IDX_W-1:0] NR = RK_IDX_W'(NUM_ROUNDS);

    logic [1:0]          st_q, st_d;
    logic [RK_IDX_W-1:0] cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [127:0]        state_q, state_d;
    logic                mode_eff, last_round, accept;
    logic [RK_IDX_W-1:0] load_idx;
    logic [127:0]        text_in, round_key, shifted, fwd_next, inv_next;

    assign text_in    = {text_0_in, text_1_in, text_2_in, text_3_in};
    assign round_key  = {key_0_in, key_1_in, key_2_in, key_3_in};
    assign mode_eff   = ENABLE_DECRYPT ? mode_in : 1'b0;
    assign last_round = (cnt_q == NR);
    assign load_idx   = mode_eff ? NR : '0;

    assign in_ready  = (st_q == ST_IDLE) || ((st_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (st_q == ST_DONE);
    assign busy      = (st_q != ST_IDLE);
    assign round_cnt = cnt_q;
    assign {text_0_out, text_1_out, text_2_out, text_3_out} = state_q;

    // A reload from DONE needs the same initial key an IDLE accept would fetch.
    always_comb begin
        rk_idx = '0;
        case (st_q)
            ST_IDLE: rk_idx = load_idx;
            ST_RUN:  rk_idx = mode_q ? (NR - cnt_q) : cnt_q;
            ST_DONE: rk_idx = (out_ready && in_valid) ? load_idx : '0;
            default: rk_idx = '0;
        endcase
    end

    assign shifted  = shift_rows(sub_bytes(state_q));
    assign fwd_next = (last_round ? shifted : mix_columns(shifted)) ^ round_key;

    if (ENABLE_DECRYPT) begin : g_inv
        aes_inv_round_path u_inv (
            .state_i (state_q),
            .key_i   (round_key),
            .last_i  (last_round),
            .state_o (inv_next)
        );
    end else begin : g_no_inv
        assign inv_next = state_q;
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        state_d = state_q;
        case (st_q)
            ST_IDLE: ;
            ST_RUN: begin
                state_d = mode_q ? inv_next : fwd_next;
                if (last_round) st_d = ST_DONE;
                else            cnt_d = cnt_q + 1'b1;
            end
            ST_DONE: if (out_ready && !in_valid) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        // Round 0 (initial AddRoundKey) is folded into the accept edge.
        if (accept) begin
            st_d    = ST_RUN;
            cnt_d   = RK_IDX_W'(1);
            mode_d  = mode_eff;
            state_d = text_in ^ round_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end
endmodule
